// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver: hex segment table,
// segment bit indices and the logical all-off pattern.
package seven_seg_pkg;

  typedef enum int {
    SEG_A = 0,
    SEG_B = 1,
    SEG_C = 2,
    SEG_D = 3,
    SEG_E = 4,
    SEG_F = 5,
    SEG_G = 6
  } seg_bit_e;

  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Index 15 first: packed array concatenation fills from the top entry down.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b1110001,  // F
    7'b1111001,  // E
    7'b1011110,  // d
    7'b0111001,  // C
    7'b1111100,  // b
    7'b1110111,  // A
    7'b1101111,  // 9
    7'b1111111,  // 8
    7'b0000111,  // 7
    7'b1111101,  // 6
    7'b1101101,  // 5
    7'b1100110,  // 4
    7'b1001111,  // 3
    7'b1011011,  // 2
    7'b0000110,  // 1
    7'b0111111   // 0
  };

  function automatic logic [6:0] seg_lookup(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// Load-side bus of the seven-segment scan driver: value/dp/enable words,
// the load strobe and the busy (commit pending) flag.
interface seven_seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] data;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    load;
  logic                    busy;

  modport master (
    output data,
    output dp,
    output digit_en,
    output load,
    input  busy
  );

  modport slave (
    input  data,
    input  dp,
    input  digit_en,
    input  load,
    output busy
  );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to seven-segment pattern (bit0 = a .. bit6 = g),
// logical polarity: 1 means segment lit.
module hex_to_seg7
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = seg_lookup(nibble);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with frame-synchronous commit.
// Optional macro SEVEN_SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 1,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  seven_seg_scan_driver_if.slave   bus,
  output logic [6:0]               seg,
  output logic                     dp_out,
  output logic [NUM_DIGITS-1:0]    an,
  output logic                     frame_done
);

  localparam int PRESC_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

  localparam logic [6:0]            SEG_PIN_OFF = SEG_OFF ^ {7{SEG_INV}};
  localparam logic                  DP_PIN_OFF  = SEG_INV;
  localparam logic [NUM_DIGITS-1:0] AN_PIN_OFF  = {NUM_DIGITS{AN_INV}};

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("seven_seg_scan_driver: NUM_DIGITS must be 1..8");
  end
  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("seven_seg_scan_driver: SCAN_DIV must be at least 2");
  end
  if (BLANK_CYCLES < 0 || BLANK_CYCLES >= SCAN_DIV) begin : g_bad_blank
    $error("seven_seg_scan_driver: BLANK_CYCLES must be 0..SCAN_DIV-1");
  end

  logic [PRESC_W-1:0] presc;
  logic [IDX_W-1:0]   idx;
  logic               slot_end;
  logic               frame_tick;

  logic [4*NUM_DIGITS-1:0] shadow_data;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [NUM_DIGITS-1:0]   shadow_en;
  logic [4*NUM_DIGITS-1:0] act_data;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic [NUM_DIGITS-1:0]   act_en;

  logic [3:0]            cur_nibble;
  logic                  cur_dp;
  logic                  cur_en;
  logic                  cur_lz;
  logic [6:0]            cur_pattern;
  logic [6:0]            seg_next;
  logic                  dp_next;
  logic [NUM_DIGITS-1:0] an_next;
  logic                  blank_gap;

  assign slot_end   = (presc == PRESC_LAST);
  assign frame_tick = slot_end && (idx == IDX_LAST);
  assign frame_done = frame_tick;
  assign blank_gap  = (int'(presc) < BLANK_CYCLES);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (slot_end) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // A load always wins over a commit in the same cycle, so the freshly
  // written shadow survives until the following frame boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
      shadow_en   <= '0;
      act_data    <= '0;
      act_dp      <= '0;
      act_en      <= '0;
      bus.busy    <= 1'b0;
    end else if (bus.load) begin
      shadow_data <= bus.data;
      shadow_dp   <= bus.dp;
      shadow_en   <= bus.digit_en;
      bus.busy    <= 1'b1;
    end else if (frame_tick && bus.busy) begin
      act_data <= shadow_data;
      act_dp   <= shadow_dp;
      act_en   <= shadow_en;
      bus.busy <= 1'b0;
    end
  end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_mask;

  // Walk down from the MSD; every digit above the first non-zero nibble is
  // blanked. Digit 0 never gets a mask bit.
  always_comb begin
    logic seen;
    lz_mask = '0;
    seen    = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (act_data[4*k +: 4] != 4'h0) seen = 1'b1;
      lz_mask[k] = ~seen;
    end
  end
`endif

  always_comb begin
    cur_nibble = 4'h0;
    cur_dp     = 1'b0;
    cur_en     = 1'b0;
    cur_lz     = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_nibble = act_data[4*k +: 4];
        cur_dp     = act_dp[k];
        cur_en     = act_en[k];
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        cur_lz     = lz_mask[k];
`endif
      end
    end
  end

  hex_to_seg7 u_decode (
    .nibble (cur_nibble),
    .seg    (cur_pattern)
  );

  always_comb begin
    seg_next = SEG_OFF;
    dp_next  = 1'b0;
    an_next  = '0;
    if (!blank_gap) begin
      an_next = NUM_DIGITS'(1) << idx;
      if (cur_en) begin
        seg_next = cur_lz ? SEG_OFF : cur_pattern;
        dp_next  = cur_dp;
      end
    end
  end

  // Pin registers apply polarity last so the decode path stays active-high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg    <= SEG_PIN_OFF;
      dp_out <= DP_PIN_OFF;
      an     <= AN_PIN_OFF;
    end else begin
      seg    <= seg_next ^ {7{SEG_INV}};
      dp_out <= dp_next ^ SEG_INV;
      an     <= an_next ^ {NUM_DIGITS{AN_INV}};
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver (4 digits, SCAN_DIV=4, BLANK_CYCLES=1);
// expectations follow SEVEN_SEG_LEADING_ZERO_BLANK_EN when it is defined.
module tb_seven_seg_scan_driver;

  localparam int N = 4;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] HI_ZERO = 7'b0000000;
`else
  localparam logic [6:0] HI_ZERO = 7'b0111111;
`endif

  logic         clk;
  logic         reset;
  logic [6:0]   seg;
  logic         dp_out;
  logic [N-1:0] an;
  logic         frame_done;

  int vectors;
  int miscompares;
  int cyc;

  seven_seg_scan_driver_if #(.NUM_DIGITS(N)) bus ();

  seven_seg_scan_driver #(
    .NUM_DIGITS     (N),
    .SCAN_DIV       (4),
    .BLANK_CYCLES   (1),
    .SEG_ACTIVE_LOW (0),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .seg        (seg),
    .dp_out     (dp_out),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Outputs are sampled 1 time unit after each rising edge; cyc counts edges
  // since the last reset release.
  task automatic step_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] d, input logic [3:0] p,
                                input logic [3:0] e);
    bus.data     = d;
    bus.dp       = p;
    bus.digit_en = e;
    bus.load     = 1'b1;
    step_to(cyc + 1);
    bus.load     = 1'b0;
  endtask

  task automatic check_slot(input string tag, input logic [3:0] exp_an,
                            input logic [6:0] exp_seg, input logic exp_dp);
    check_output({tag, "_an"}, 16'(an), 16'(exp_an));
    check_output({tag, "_seg"}, 16'(seg), 16'(exp_seg));
    check_output({tag, "_dp"}, 16'(dp_out), 16'(exp_dp));
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    cyc          = 0;
    reset        = 1'b1;
    bus.data     = '0;
    bus.dp       = '0;
    bus.digit_en = '0;
    bus.load     = 1'b0;

    #1;
    check_slot("por", 4'b1111, 7'b0000000, 1'b0);
    check_output("por_busy", 16'(bus.busy), 16'd0);
    check_output("por_fd", 16'(frame_done), 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;

    step_to(1);
    check_slot("rel_c1", 4'b1111, 7'b0000000, 1'b0);
    step_to(2);
    check_slot("rel_c2", 4'b1110, 7'b0000000, 1'b0);

    // First load: 12AF with dp on digit 2
    apply_stimulus(16'h12AF, 4'b0100, 4'hF);
    check_output("ld1_busy", 16'(bus.busy), 16'd1);
    step_to(15);
    check_output("fd_c15", 16'(frame_done), 16'd1);
    check_output("busy_c15", 16'(bus.busy), 16'd1);
    step_to(16);
    check_output("busy_c16", 16'(bus.busy), 16'd0);
    check_output("fd_c16", 16'(frame_done), 16'd0);
    step_to(17);
    check_slot("gap_c17", 4'b1111, 7'b0000000, 1'b0);
    step_to(18);
    check_slot("d0_F", 4'b1110, 7'b1110001, 1'b0);
    step_to(22);
    check_slot("d1_A", 4'b1101, 7'b1110111, 1'b0);
    step_to(25);
    check_slot("gap_c25", 4'b1111, 7'b0000000, 1'b0);
    step_to(26);
    check_slot("d2_2", 4'b1011, 7'b1011011, 1'b1);
    step_to(30);
    check_slot("d3_1", 4'b0111, 7'b0000110, 1'b0);
    check_output("fd_c30", 16'(frame_done), 16'd0);
    step_to(31);
    check_output("fd_c31", 16'(frame_done), 16'd1);

    // Load coincident with frame_done: shadow only, commit one frame later
    apply_stimulus(16'h8888, 4'b0000, 4'b1011);
    check_output("coin_busy_c32", 16'(bus.busy), 16'd1);
    check_output("fd_c32", 16'(frame_done), 16'd0);
    step_to(34);
    check_slot("coin_old_d0", 4'b1110, 7'b1110001, 1'b0);
    step_to(46);
    check_output("fd_c46", 16'(frame_done), 16'd0);
    step_to(47);
    check_output("fd_c47", 16'(frame_done), 16'd1);
    check_output("coin_busy_c47", 16'(bus.busy), 16'd1);
    step_to(48);
    check_output("coin_busy_c48", 16'(bus.busy), 16'd0);
    step_to(50);
    check_slot("en_d0", 4'b1110, 7'b1111111, 1'b0);
    step_to(54);
    check_slot("en_d1", 4'b1101, 7'b1111111, 1'b0);
    step_to(58);
    check_slot("en_d2_off", 4'b1011, 7'b0000000, 1'b0);
    step_to(62);
    check_slot("en_d3", 4'b0111, 7'b1111111, 1'b0);

    // Leading-zero pattern 0050, dp on digit 3
    apply_stimulus(16'h0050, 4'b1000, 4'hF);
    check_output("lz_busy_c63", 16'(bus.busy), 16'd1);
    step_to(64);
    check_output("lz_busy_c64", 16'(bus.busy), 16'd0);
    step_to(66);
    check_slot("lz_d0", 4'b1110, 7'b0111111, 1'b0);
    step_to(70);
    check_slot("lz_d1", 4'b1101, 7'b1101101, 1'b0);
    step_to(74);
    check_slot("lz_d2", 4'b1011, HI_ZERO, 1'b0);
    step_to(78);
    check_slot("lz_d3", 4'b0111, HI_ZERO, 1'b1);

    apply_stimulus(16'h0000, 4'b0000, 4'hF);
    step_to(82);
    check_slot("zero_d0", 4'b1110, 7'b0111111, 1'b0);
    step_to(86);
    check_slot("zero_d1", 4'b1101, HI_ZERO, 1'b0);

    // Pending load, then reset in the middle of slot 2 discards it
    apply_stimulus(16'hFFFF, 4'hF, 4'hF);
    step_to(90);
    check_output("pre_rst_busy", 16'(bus.busy), 16'd1);
    check_slot("pre_rst_d2", 4'b1011, HI_ZERO, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_slot("mid_rst", 4'b1111, 7'b0000000, 1'b0);
    check_output("mid_rst_busy", 16'(bus.busy), 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    step_to(1);
    check_slot("rst2_c1", 4'b1111, 7'b0000000, 1'b0);
    step_to(2);
    check_slot("rst2_c2", 4'b1110, 7'b0000000, 1'b0);
    step_to(15);
    check_output("rst2_fd_c15", 16'(frame_done), 16'd1);
    step_to(18);
    check_slot("rst2_nocommit", 4'b1110, 7'b0000000, 1'b0);
    check_output("rst2_busy", 16'(bus.busy), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
